// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder with programmable wait states.
// A request is captured in IDLE, aged in WAIT, then checked and executed on the first RESP
// cycle; the registered response is held in RESP until the initiator takes it.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] mem_idx;
  logic [1:0]       lane;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [31:0]      merged_word;
  logic             out_of_range;
  logic             misaligned;
  logic             req_error;
  logic             mem_we;
  logic [31:0]      mem_wdata;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Address decode and byte-lane views of the captured request.
  assign mem_idx      = addr_q[IDX_W+1:2];
  assign lane         = addr_q[1:0];
  assign rd_word      = mem[mem_idx];
  assign out_of_range = (addr_q[31:2] >= 30'(DEPTH_WORDS));
  assign misaligned   = !byte_q && (addr_q[1:0] != 2'b00);
  assign req_error    = out_of_range || misaligned;

  // Pick the addressed lane for byte loads and splice the store byte into the old word.
  always_comb begin
    rd_byte     = rd_word[7:0];
    merged_word = rd_word;
    case (lane)
      2'd0: begin
        rd_byte     = rd_word[7:0];
        merged_word = {rd_word[31:8], wdata_q[7:0]};
      end
      2'd1: begin
        rd_byte     = rd_word[15:8];
        merged_word = {rd_word[31:16], wdata_q[7:0], rd_word[7:0]};
      end
      2'd2: begin
        rd_byte     = rd_word[23:16];
        merged_word = {rd_word[31:24], wdata_q[7:0], rd_word[15:0]};
      end
      default: begin
        rd_byte     = rd_word[31:24];
        merged_word = {wdata_q[7:0], rd_word[23:0]};
      end
    endcase
  end

  // State and response registers; storage is deliberately outside the reset domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      byte_q      <= byte_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic: accept in IDLE, count down wait states, leave RESP on handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: capture the request, execute it once on RESP entry, clear on handshake.
  always_comb begin
    we_d        = we_q;
    byte_d      = byte_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;
    mem_wdata   = rd_word;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          byte_d  = req_byte;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      S_RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = req_error;
          if (!req_error) begin
            if (we_q) begin
              mem_we    = 1'b1;
              mem_wdata = byte_q ? merged_word : wdata_q;
            end else begin
              rsp_rdata_d = byte_q ? {24'd0, rd_byte} : rd_word;
            end
          end
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // Storage write port; commits stores on the RESP entry edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vector table against a WAIT_CYCLES=2 instance, plus
// hand-written backpressure, mid-operation reset and WAIT_CYCLES=0 throughput sequences.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_ready, req_we, req_byte;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we, b_req_byte;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    bit          we;
    bit          byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_fast (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we), .req_byte(b_req_byte),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic vec_t mkVec(string name, bit we, bit byt, logic [31:0] addr,
                                 logic [31:0] wdata, logic [31:0] exp_rdata, bit exp_err);
    vec_t v;
    v.name      = name;
    v.we        = we;
    v.byt       = byt;
    v.addr      = addr;
    v.wdata     = wdata;
    v.exp_rdata = exp_rdata;
    v.exp_err   = exp_err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance; returns response and accept-to-valid edges.
  task automatic applyStimulus(input bit we, input bit byt, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic err, output int lat);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("req_ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_byte  = byt;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata     = rsp_rdata;
    err       = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // Watchdog so a stuck handshake still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed test sequence.
  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_byte = 1'b0; b_req_addr = 32'd0; b_req_wdata = 32'd0;
    b_rsp_ready = 1'b0;

    vecs.push_back(mkVec("st_word_10",     1, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mkVec("ld_word_10",     0, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mkVec("st_word_20",     1, 0, 32'h20,  32'h11223344, 32'h0,        0));
    vecs.push_back(mkVec("strb_22",        1, 1, 32'h22,  32'hFFFFFFAA, 32'h0,        0));
    vecs.push_back(mkVec("ld_word_20",     0, 0, 32'h20,  32'h0,        32'h11AA3344, 0));
    vecs.push_back(mkVec("ldrb_23",        0, 1, 32'h23,  32'h0,        32'h00000011, 0));
    vecs.push_back(mkVec("ldrb_20",        0, 1, 32'h20,  32'h0,        32'h00000044, 0));
    vecs.push_back(mkVec("strb_21",        1, 1, 32'h21,  32'h1234565A, 32'h0,        0));
    vecs.push_back(mkVec("ld_word_20_b",   0, 0, 32'h20,  32'h0,        32'h11AA5A44, 0));
    vecs.push_back(mkVec("st_word_00",     1, 0, 32'h0,   32'hCAFEF00D, 32'h0,        0));
    vecs.push_back(mkVec("ld_misalign_06", 0, 0, 32'h06,  32'h0,        32'h0,        1));
    vecs.push_back(mkVec("st_oor_100",     1, 0, 32'h100, 32'h12345678, 32'h0,        1));
    vecs.push_back(mkVec("st_misalign_02", 1, 0, 32'h02,  32'h87654321, 32'h0,        1));
    vecs.push_back(mkVec("ld_word_00",     0, 0, 32'h0,   32'h0,        32'hCAFEF00D, 0));
    vecs.push_back(mkVec("st_word_fc",     1, 0, 32'hFC,  32'h0BADC0DE, 32'h0,        0));
    vecs.push_back(mkVec("ld_word_fc",     0, 0, 32'hFC,  32'h0,        32'h0BADC0DE, 0));
    vecs.push_back(mkVec("ldrb_ff",        0, 1, 32'hFF,  32'h0,        32'h0000000B, 0));
    vecs.push_back(mkVec("ldrb_oor_104",   0, 1, 32'h104, 32'h0,        32'h0,        1));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_rsp_err",   32'(rsp_err), 32'd0);
    checkOutput("reset_fast_req_ready", 32'(b_req_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].byt, vecs[i].addr, vecs[i].wdata, rdata, err, lat);
      checkOutput({vecs[i].name, "_rdata"},   rdata, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, "_err"},     32'(err), 32'(vecs[i].exp_err));
      checkOutput({vecs[i].name, "_latency"}, 32'(lat), 32'd3);
    end

    // Backpressure: response held while rsp_ready is low, competing request ignored.
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 32'h10; req_wdata = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("bp_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h00000099;
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      checkOutput("bp_rsp_err",   32'(rsp_err), 32'd0);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("bp_release_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp_release_rdata", rsp_rdata, 32'd0);
    checkOutput("bp_release_ready", 32'(req_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h10, 32'd0, rdata, err, lat);
    checkOutput("bp_second_req_dropped", rdata, 32'hDEADBEEF);

    // Reset during WAIT of a store: the store must be dropped.
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, rdata, err, lat);
    checkOutput("rst_prep_err", 32'(err), 32'd0);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h30; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    @(posedge clk); #1;
    checkOutput("rst_in_wait_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_mid_rsp_err",   32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 32'h30, 32'd0, rdata, err, lat);
    checkOutput("rst_dropped_store", rdata, 32'd0);
    checkOutput("rst_dropped_err",   32'(err), 32'd0);
    checkOutput("rst_dropped_lat",   32'(lat), 32'd3);

    // WAIT_CYCLES=0 instance: continuous stores with rsp_ready high, one response every 3 cycles.
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_byte = 1'b0; b_req_addr = 32'h8; b_req_wdata = 32'h77;
    b_rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("fast_rsp_valid_%0d", k), 32'(b_rsp_valid), 32'((k % 3) == 1));
      checkOutput($sformatf("fast_req_ready_%0d", k), 32'(b_req_ready), 32'((k % 3) == 2));
    end
    b_req_we = 1'b0; b_req_wdata = 32'd0;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    checkOutput("fast_load_accept_valid", 32'(b_rsp_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("fast_load_valid", 32'(b_rsp_valid), 32'd1);
    checkOutput("fast_load_rdata", b_rsp_rdata, 32'h77);
    checkOutput("fast_load_err",   32'(b_rsp_err), 32'd0);
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
    checkOutput("fast_idle_ready", 32'(b_req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
